sync_w2r_gray: RTL

SYNC_W2R_GRAY -- requirements
Module: sync_w2r_gray

---
 rtl/sync_w2r_gray_if.sv | 26 ++
 rtl/sync_w2r_gray.sv | 93 +++++++++
 2 files changed

// File: rtl/sync_w2r_gray_if.sv
// Signal bundle between a FIFO read side and its write-pointer synchronizer.
// The master drives the write pointer, read pointer and error clear. The slave drives the status outputs.
interface sync_w2r_gray_if #(
  parameter int ADDRSIZE = 4
);
  logic [ADDRSIZE:0] wptr;
  logic [ADDRSIZE:0] rptr_bin;
  logic              err_clr;
  logic [ADDRSIZE:0] rq_wptr_gray;
  logic [ADDRSIZE:0] rq_wptr_bin;
  logic              wptr_upd;
  logic [ADDRSIZE:0] rcount;
  logic              rempty;
  logic              ralmost_empty;
  logic              sync_err;

  modport master (
    output wptr, rptr_bin, err_clr,
    input  rq_wptr_gray, rq_wptr_bin, wptr_upd, rcount, rempty, ralmost_empty, sync_err
  );

  modport slave (
    input  wptr, rptr_bin, err_clr,
    output rq_wptr_gray, rq_wptr_bin, wptr_upd, rcount, rempty, ralmost_empty, sync_err
  );
endinterface

// File: rtl/sync_w2r_gray.sv
// Brings a Gray-coded FIFO write pointer into the read clock domain.
// Derives the read-side word count, the empty and almost-empty flags, and a sticky pointer-integrity error.
module sync_w2r_gray #(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 1
) (
  input logic            rclk,
  input logic            rrst,
  sync_w2r_gray_if.slave bus
);
  localparam int PW = ADDRSIZE + 1;
  typedef logic [PW-1:0] ptr_t;

  ptr_t sync_q [SYNC_STAGES];
  ptr_t prev_gray_q;
  ptr_t wbin_q;
  ptr_t rcount_q;
  logic upd_q;
  logic rempty_q;
  logic ralmost_empty_q;
  logic sync_err_q;

  ptr_t gray_s;
  ptr_t wbin_d;
  ptr_t rcount_d;
  ptr_t gray_diff;
  logic jump_err;
  logic ovf_err;
  logic sync_err_d;

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = '0;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // A legal Gray step flips at most one bit, so a diff with two or more set bits is a torn sample.
  always_comb begin
    gray_s     = sync_q[SYNC_STAGES-1];
    wbin_d     = gray2bin(gray_s);
    rcount_d   = wbin_q - bus.rptr_bin;
    gray_diff  = gray_s ^ prev_gray_q;
    jump_err   = (gray_diff & (gray_diff - ptr_t'(1))) != '0;
    ovf_err    = 32'(rcount_d) > 32'(2**ADDRSIZE);
    sync_err_d = sync_err_q;
    if (bus.err_clr) begin
      sync_err_d = 1'b0;
    end
    if (jump_err || ovf_err) begin
      sync_err_d = 1'b1;
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      prev_gray_q     <= '0;
      wbin_q          <= '0;
      rcount_q        <= '0;
      upd_q           <= 1'b0;
      rempty_q        <= 1'b1;
      ralmost_empty_q <= 1'b1;
      sync_err_q      <= 1'b0;
    end else begin
      sync_q[0] <= bus.wptr;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      prev_gray_q     <= gray_s;
      wbin_q          <= wbin_d;
      upd_q           <= (wbin_d != wbin_q);
      rcount_q        <= rcount_d;
      rempty_q        <= (rcount_d == '0);
      ralmost_empty_q <= (32'(rcount_d) <= 32'(AE_THRESH));
      sync_err_q      <= sync_err_d;
    end
  end

  assign bus.rq_wptr_gray  = gray_s;
  assign bus.rq_wptr_bin   = wbin_q;
  assign bus.wptr_upd      = upd_q;
  assign bus.rcount        = rcount_q;
  assign bus.rempty        = rempty_q;
  assign bus.ralmost_empty = ralmost_empty_q;
  assign bus.sync_err      = sync_err_q;
endmodule
